// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM encoding and GF(2^8) helpers
package aes_pkg;

    localparam int          AES_NR       = 14;
    localparam logic [3:0]  AES_LAST_RND = 4'(AES_NR);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_KEYREQ  = 3'd1,
        S_KEYWAIT = 3'd2,
        S_ROUND   = 3'd3,
        S_DONE    = 3'd4
    } aes_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] s;
        s = 8'h00;
        case (b)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// rtl/aes_round_comb.sv - one combinational AES round (SubBytes/ShiftRows/MixColumns/AddRoundKey)
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic         rc_is0,
    input  logic         rc_is_last,
    output logic [127:0] st_next
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] pre;
        st_next = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(st[127-8*i -: 8]);
        end
        // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        for (int i = 0; i < 16; i++) begin
            if (rc_is0) begin
                pre = st[127-8*i -: 8];
            end else if (rc_is_last) begin
                pre = sr[i];
            end else begin
                pre = mc[i];
            end
            st_next[127-8*i -: 8] = pre ^ rk[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes256_enc_core.sv
// rtl/aes256_enc_core.sv - iterative AES-256 encrypt core reading round keys from the key controller
// Optional AES_KEY_REUSE_EN: skip re-expansion when a block carries the already-expanded key.
module aes256_enc_core
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR,
    parameter int KEY_W      = 256
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     plaintext,
    input  logic [KEY_W-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     ciphertext,
    output logic             key_ctrl_en,
    output logic [KEY_W-1:0] key_out,
    output logic             mode,
    output logic [3:0]       round,
    input  logic [127:0]     round_key,
    input  logic             key_ready
);

    aes_state_e       state_q, state_d;
    logic [127:0]     st_q, st_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [3:0]       rc_q, rc_d;
    logic [127:0]     st_rnd;
    logic             rc_is_last;
`ifdef AES_KEY_REUSE_EN
    logic             key_vld_q, key_vld_d;
`endif

    assign rc_is_last = (rc_q == 4'(NUM_ROUNDS));

    aes_round_comb u_round (
        .st         (st_q),
        .rk         (round_key),
        .rc_is0     (rc_q == 4'd0),
        .rc_is_last (rc_is_last),
        .st_next    (st_rnd)
    );

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        key_d   = key_q;
        rc_d    = rc_q;
`ifdef AES_KEY_REUSE_EN
        key_vld_d = key_vld_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    st_d    = plaintext;
                    key_d   = key;
                    rc_d    = 4'd0;
`ifdef AES_KEY_REUSE_EN
                    if (key_vld_q && (key == key_q)) begin
                        state_d = S_ROUND;
                    end else begin
                        key_vld_d = 1'b0;
                        state_d   = S_KEYREQ;
                    end
`else
                    state_d = S_KEYREQ;
`endif
                end
            end
            S_KEYREQ: state_d = S_KEYWAIT;
            S_KEYWAIT: begin
                if (key_ready) begin
                    state_d = S_ROUND;
                    rc_d    = 4'd0;
`ifdef AES_KEY_REUSE_EN
                    key_vld_d = 1'b1;
`endif
                end
            end
            S_ROUND: begin
                st_d = st_rnd;
                if (rc_is_last) begin
                    state_d = S_DONE;
                end else if (rc_q != AES_LAST_RND) begin
                    rc_d = rc_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= S_IDLE;
            st_q    <= '0;
            key_q   <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            key_q   <= key_d;
            rc_q    <= rc_d;
        end
    end

`ifdef AES_KEY_REUSE_EN
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            key_vld_q <= 1'b0;
        end else begin
            key_vld_q <= key_vld_d;
        end
    end
`endif

    // in_ready is masked by reset so it reads 0 while reset is held.
    assign in_ready    = srst_n && (state_q == S_IDLE);
    assign key_ctrl_en = (state_q == S_KEYREQ);
    assign out_valid   = (state_q == S_DONE);
    assign ciphertext  = out_valid ? st_q : '0;
    assign round       = (state_q == S_ROUND) ? rc_q : 4'd0;
    assign key_out     = key_q;
    assign mode        = 1'b1;

endmodule

// File: doc/aes256_enc_core.md
Name: aes256_enc_core

Overview:
- Iterative AES-256 encryption datapath; the consumer (reader) of the round-key controller's key bank.
- Accepts a plaintext/key pair and requests key expansion from the key controller.
- Once all keys are expanded, reads round keys 0..14 one per cycle by driving the round index, and runs one cipher round per cycle.
- Returns the ciphertext over a valid/ready output handshake.

Parameters:
NUM_ROUNDS, 14, cipher rounds; fixed for AES-256, not overridable in practice
KEY_W, 256, cipher key width

Ports:
clk  in  1  clock
srst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  plaintext/key offered
in_ready  out  1  core can accept (IDLE only)
plaintext  in  128  block in, byte0 = bits[127:120], column-major
key  in  256  cipher key
out_valid  out  1  ciphertext valid, held until accepted
out_ready  in  1  downstream accepts
ciphertext  out  128  result, same byte order
key_ctrl_en  out  1  one-cycle expansion request to key controller
key_out  out  256  registered key to key controller, stable from request until key_ready
mode  out  1  constant 1 (all-keys-before-ready expansion)
round  out  4  key-bank index driven to key controller
round_key  in  128  key_bank[round], combinational from key controller
key_ready  in  1  one-cycle pulse: all 15 round keys written

Behaviour:
- Reset values: in_ready=0 during reset (1 once in IDLE), out_valid=0, ciphertext=0, key_ctrl_en=0, key_out=0, round=0, state=IDLE.
- FSM states: IDLE, KEYREQ, KEYWAIT, ROUND, DONE.
- IDLE: in_ready=1. On in_valid, register plaintext into the state register and key into key_out, then go to KEYREQ.
- KEYREQ: key_ctrl_en=1 for exactly one cycle, then go to KEYWAIT.
- KEYWAIT: hold key_out. On the key_ready pulse, go to ROUND with rc=0.
- ROUND: round=rc. Per cycle:
  - rc=0: st <= st ^ round_key.
  - rc=1..13: st <= MixColumns(ShiftRows(SubBytes(st))) ^ round_key.
  - rc=14: no MixColumns, then go to DONE.
  - rc increments every cycle, 15 cycles total.
- DONE: out_valid=1, ciphertext=st. Both are held while out_ready=0. On out_valid&out_ready, go to IDLE next cycle with out_valid=0.
- Latency with the paired key controller:
  - Accept at T0, key_ctrl_en at T1, key_ready at T29.
  - ROUND T30..T44, out_valid from T45.
- key_ready pulse outside KEYWAIT: ignored. It must not advance the FSM.
- in_valid while not IDLE: not accepted (in_ready=0); plaintext/key ignored.
- out_ready asserted without out_valid: no effect.
- Reset asserted mid-operation (any state): immediately returns to IDLE, all outputs take their reset values, any partial state is discarded.
- round wraps never: rc saturates at 14 until DONE; round=0 outside ROUND.
- Arithmetic: GF(2^8), polynomial 0x11b; xtime(b) = {b[6:0],0} ^ (0x1b & {8{b[7]}}).

Optional Feature:
- Macro: AES_KEY_REUSE_EN.
- When defined:
  - A key_vld flag is set on key_ready and cleared on reset.
  - On accept, if key_vld and key==key_out, IDLE goes directly to ROUND, skipping KEYREQ/KEYWAIT. Latency: accept T0, ROUND T1..T15, out_valid T16.
  - A differing key clears key_vld and takes the normal path.
- When undefined: every block re-requests expansion; no key_vld register.

Decomposition:
- Package aes_pkg:
  - sbox function (256-entry case).
  - xtime function.
  - FSM state encoding constants.
  - AES_NR=14 and AES_LAST_RND constants.
- Sub-module aes_round_comb (combinational): inputs st, rk, rc_is0, rc_is_last; output next state. Implements SubBytes/ShiftRows/MixColumns/AddRoundKey.
- The core holds only the FSM, counters, registers and handshakes.

Test Plan:
- FIPS-197 C.3: key=000102..1e1f, pt=00112233445566778899aabbccddeeff, paired with the key controller -> ciphertext=8ea2b7ca516745bfeafc49904b496089; out_valid first at T45; key_ctrl_en high exactly one cycle at T1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> ciphertext/out_valid stable throughout, in_ready=0; out_ready=1 -> in_ready=1 the following cycle.
- Spurious key_ready pulse in IDLE and in ROUND -> FSM, round sequence and result unchanged (same C.3 result).
- Reset asserted during ROUND at rc=7 -> out_valid, key_ctrl_en, round all 0 immediately; after release, a new C.3 block completes correctly.
- in_valid held high with new data while busy -> second block accepted only in the cycle in_ready=1; both ciphertexts correct and in order.
- AES_KEY_REUSE_EN: two blocks with the same key -> second block has no key_ctrl_en pulse and out_valid 16 cycles after accept; a third block with a new key -> key_ctrl_en pulses again.
